// File: rtl/integrador_dupla_rampa.sv
// Cycle-accurate dual-slope integrator with zero-crossing comparator.
// Integrates vm, de-integrates vref and emits a single Vint_z pulse per reference ramp.
module integrador_dupla_rampa #(
  parameter int VIN_W = 10,
  parameter int ACC_W = 20
) (
  input  logic             ck,
  input  logic             rst_s,
  input  logic             ch_zr,
  input  logic             ch_vm,
  input  logic             ch_ref,
  input  logic [VIN_W-1:0] vm,
  input  logic [VIN_W-1:0] vref,
  output logic             Vint_z,
  output logic [ACC_W-1:0] vint,
  output logic             sat,
  output logic             erro
);

  localparam int PAD = ACC_W - VIN_W;

  typedef enum logic [2:0] {
    HOLD,
    AUTOZERO,
    INTEGRA,
    DESINTEGRA,
    ILEGAL
  } modo_t;

  modo_t            modo;
  logic             armado;
  logic             armado_n;
  logic [ACC_W-1:0] vint_n;
  logic             vint_z_n;
  logic             sat_n;
  logic             erro_n;
  logic [ACC_W:0]   soma;
  logic [ACC_W-1:0] vref_ext;

  function automatic logic [ACC_W-1:0] ext_code(input logic [VIN_W-1:0] c);
    return {{PAD{1'b0}}, c};
  endfunction

  // MSB of the result is the overflow flag; the low bits are already clamped.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [VIN_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, ext_code(b)};
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  always_comb begin
    unique case ({ch_zr, ch_vm, ch_ref})
      3'b000:  modo = HOLD;
      3'b100:  modo = AUTOZERO;
      3'b010:  modo = INTEGRA;
      3'b001:  modo = DESINTEGRA;
      default: modo = ILEGAL;
    endcase
  end

  assign soma     = sat_add(vint, vm);
  assign vref_ext = ext_code(vref);

  always_comb begin
    vint_n   = vint;
    vint_z_n = 1'b0;
    sat_n    = sat;
    erro_n   = erro;
    armado_n = armado;
    unique case (modo)
      HOLD: armado_n = 1'b1;
      AUTOZERO: begin
        vint_n   = '0;
        sat_n    = 1'b0;
        erro_n   = 1'b0;
        armado_n = 1'b1;
      end
      INTEGRA: begin
        vint_n = soma[ACC_W-1:0];
        if (soma[ACC_W]) sat_n = 1'b1;
      end
      DESINTEGRA: begin
        if (vref == '0) begin
          erro_n = 1'b1;
        end else if (vint > vref_ext) begin
          vint_n = vint - vref_ext;
        end else begin
          // Crossing reached: only the first one in this ramp produces a pulse.
          vint_n   = '0;
          vint_z_n = armado;
          armado_n = 1'b0;
        end
      end
      ILEGAL: erro_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst_s) begin
      vint   <= '0;
      Vint_z <= 1'b0;
      sat    <= 1'b0;
      erro   <= 1'b0;
      armado <= 1'b1;
    end else begin
      vint   <= vint_n;
      Vint_z <= vint_z_n;
      sat    <= sat_n;
      erro   <= erro_n;
      armado <= armado_n;
    end
  end

endmodule

// File: tb/tb_integrador_dupla_rampa.sv
// Directed bench for integrador_dupla_rampa: vector table plus multi-cycle ramp sequences.
module tb_integrador_dupla_rampa;

  logic        ck = 1'b0;
  logic        rst_s, ch_zr, ch_vm, ch_ref;
  logic [9:0]  vm, vref;
  logic        Vint_z, sat, erro;
  logic [19:0] vint;
  logic        Vint_z_s, sat_s, erro_s;
  logic [11:0] vint_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ck = ~ck;

  integrador_dupla_rampa #(.VIN_W(10), .ACC_W(20)) u_dut (
    .ck(ck), .rst_s(rst_s), .ch_zr(ch_zr), .ch_vm(ch_vm), .ch_ref(ch_ref),
    .vm(vm), .vref(vref), .Vint_z(Vint_z), .vint(vint), .sat(sat), .erro(erro)
  );

  integrador_dupla_rampa #(.VIN_W(10), .ACC_W(12)) u_sat (
    .ck(ck), .rst_s(rst_s), .ch_zr(ch_zr), .ch_vm(ch_vm), .ch_ref(ch_ref),
    .vm(vm), .vref(vref), .Vint_z(Vint_z_s), .vint(vint_s), .sat(sat_s), .erro(erro_s)
  );

  typedef struct {
    logic        zr, vs, rs;
    logic [9:0]  vm, vref;
    int          ev;
    logic        ez, es, ee;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit zr, bit vs, bit rs, int a, int r,
                              int ev, bit ez, bit es, bit ee);
    vec_t v;
    v.zr = zr; v.vs = vs; v.rs = rs;
    v.vm = 10'(a); v.vref = 10'(r);
    v.ev = ev; v.ez = ez; v.es = es; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic sw(input bit zr, input bit vs, input bit rs);
    ch_zr = zr; ch_vm = vs; ch_ref = rs;
  endtask

  int first, npulse;

  initial begin
    rst_s = 1'b1; sw(0, 0, 0); vm = '0; vref = '0;

    tbl[0]  = mk(1,0,0,   0,   0,   0, 0,0,0);
    tbl[1]  = mk(0,1,0, 100,   0, 100, 0,0,0);
    tbl[2]  = mk(0,1,0,  23,   0, 123, 0,0,0);
    tbl[3]  = mk(0,0,0,   0,   0, 123, 0,0,0);
    tbl[4]  = mk(0,0,1,   0,  50,  73, 0,0,0);
    tbl[5]  = mk(0,0,1,   0,  50,  23, 0,0,0);
    tbl[6]  = mk(0,0,1,   0,  50,   0, 1,0,0);
    tbl[7]  = mk(0,0,1,   0,  50,   0, 0,0,0);
    tbl[8]  = mk(0,0,0,   0,   0,   0, 0,0,0);
    tbl[9]  = mk(0,0,1,   0,   7,   0, 1,0,0);
    tbl[10] = mk(0,1,1,   5,   7,   0, 0,0,1);
    tbl[11] = mk(0,1,0,   5,   0,   5, 0,0,1);
    tbl[12] = mk(1,0,0,   0,   0,   0, 0,0,0);
    tbl[13] = mk(0,1,0, 700,   0, 700, 0,0,0);
    tbl[14] = mk(0,0,1,   0,   0, 700, 0,0,1);
    tbl[15] = mk(0,0,1,   0, 700,   0, 1,0,1);
    tbl[16] = mk(1,0,0,   0,   0,   0, 0,0,0);

    // Reset state
    tick();
    chk("rst_vint", int'(vint), 0);
    chk("rst_vint_z", int'(Vint_z), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_erro", int'(erro), 0);
    rst_s = 1'b0;

    // Single-cycle vector table
    for (int i = 0; i < 17; i++) begin
      sw(tbl[i].zr, tbl[i].vs, tbl[i].rs);
      vm = tbl[i].vm; vref = tbl[i].vref;
      tick();
      chk($sformatf("tbl%0d_vint", i), int'(vint), tbl[i].ev);
      chk($sformatf("tbl%0d_vint_z", i), int'(Vint_z), int'(tbl[i].ez));
      chk($sformatf("tbl%0d_sat", i), int'(sat), int'(tbl[i].es));
      chk($sformatf("tbl%0d_erro", i), int'(erro), int'(tbl[i].ee));
    end

    // Nominal conversion: 1000 x 50 then de-integrate with 100
    sw(1, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    sw(0, 1, 0); vm = 10'd50;
    for (int i = 0; i < 1000; i++) tick();
    chk("nom_vint_peak", int'(vint), 50000);
    sw(0, 0, 1); vref = 10'd100;
    first = 0; npulse = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (Vint_z) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    chk("nom_pulse_edge", first, 500);
    chk("nom_pulse_count", npulse, 1);
    chk("nom_vint_end", int'(vint), 0);
    chk("nom_sat", int'(sat), 0);
    chk("nom_erro", int'(erro), 0);

    // Saturation on the 12-bit instance
    sw(1, 0, 0); tick();
    sw(0, 1, 0); vm = 10'd1023;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("sat_vint_%0d", k), int'(vint_s), (k * 1023 > 4095) ? 4095 : k * 1023);
      chk($sformatf("sat_flag_%0d", k), int'(sat_s), (k == 5) ? 1 : 0);
    end
    chk("sat_main_clear", int'(sat), 0);
    sw(1, 0, 0); tick();
    chk("sat_az_vint", int'(vint_s), 0);
    chk("sat_az_flag", int'(sat_s), 0);

    // Re-arm rule: one pulse per continuous ch_ref interval
    sw(0, 1, 0); vm = 10'd300; tick();
    chk("rearm_vint", int'(vint), 300);
    sw(0, 0, 1); vref = 10'd100;
    first = 0; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (Vint_z) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    chk("rearm_edge", first, 3);
    chk("rearm_count", npulse, 1);
    sw(0, 0, 0); tick();
    sw(0, 0, 1);
    first = 0; npulse = 0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      if (Vint_z) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    chk("rearm2_edge", first, 1);
    chk("rearm2_count", npulse, 1);

    // Reset mid-ramp at vint=12345
    sw(1, 0, 0); tick();
    sw(0, 1, 0); vm = 10'd823;
    for (int i = 0; i < 15; i++) tick();
    chk("mid_vint", int'(vint), 12345);
    sw(0, 0, 1); vref = 10'd100; rst_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mid_rst_vint_%0d", i), int'(vint), 0);
      chk($sformatf("mid_rst_vint_z_%0d", i), int'(Vint_z), 0);
    end
    rst_s = 1'b0;
    tick();
    chk("mid_rearmed_pulse", int'(Vint_z), 1);
    tick();
    chk("mid_no_second_pulse", int'(Vint_z), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/integrador_dupla_rampa.md
Name: integrador_dupla_rampa

Overview:
- Cycle-accurate digital model of the dual-slope integrator and zero-crossing comparator.
- Responds to the switch controls ch_zr, ch_vm and ch_ref driven by maquina_de_estados.
- Generates Vint_z, replacing the hand-timed Vint_z pulse in the ADC benches, so conversions close the loop with a real measured value.
- Simulation/verification block that sits between the state machine and the 3-digit BCD counter in the top-level ADC bench.

Parameters:
- VIN_W, 10, width of the vm and vref input codes.
- ACC_W, 20, integrator accumulator width; must hold 1000*(2^VIN_W-1).

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rst_s  input  1  synchronous, active-high reset.
- ch_zr  input  1  auto-zero switch.
- ch_vm  input  1  integrate-input switch.
- ch_ref  input  1  de-integrate-reference switch.
- vm  input  VIN_W  unsigned input voltage code.
- vref  input  VIN_W  unsigned reference voltage code.
- Vint_z  output  1  registered one-cycle pulse when the integrator reaches zero during de-integration.
- vint  output  ACC_W  current accumulator value.
- sat  output  1  sticky saturation flag.
- erro  output  1  sticky illegal-control flag.

Behaviour:
- Reset: rst_s=1 at a rising edge sets vint=0, Vint_z=0, sat=0, erro=0 and armado=1 (internal). Reset overrides all switches, including mid-ramp.
- Mode is decoded each cycle from {ch_zr, ch_vm, ch_ref}. All updates take effect on the next rising edge.
- AUTOZERO (only ch_zr=1):
  - vint<=0, sat<=0, erro<=0, armado<=1, Vint_z<=0.
- INTEGRA (only ch_vm=1):
  - vint<=vint+vm.
  - If the sum exceeds 2^ACC_W-1: vint<=2^ACC_W-1 and sat<=1.
  - Vint_z<=0.
- DESINTEGRA (only ch_ref=1):
  - If vref==0: erro<=1, vint held, no pulse.
  - Else if vint>vref: vint<=vint-vref, Vint_z<=0.
  - Else (vint<=vref, including vint==0): vint<=0. If armado=1: Vint_z<=1 and armado<=0. If armado=0: Vint_z<=0.
- HOLD (all switches 0): vint held, Vint_z<=0, armado<=1.
- ILEGAL (two or more switches 1): erro<=1, vint held, Vint_z<=0.
- Vint_z:
  - Never high for more than one consecutive cycle.
  - At most one pulse per continuous ch_ref interval.
  - Re-armed only by HOLD, AUTOZERO or reset.
- Latency:
  - The crossing is detected at the edge that processes the N-th ch_ref cycle.
  - Vint_z is high for the cycle following that edge.
  - N = ceil(vint_at_start/vref), or N=1 if vint_at_start==0.
- sat and erro clear only by reset or AUTOZERO. They do not block operation (except erro from vref==0).
- vm and vref are sampled every cycle; changes mid-integration take effect immediately.

Test Plan:
- Nominal conversion: reset, ch_zr 4 cycles, ch_vm 1000 cycles with vm=50, then ch_ref with vref=100 -> vint=50000 at the ch_vm→ch_ref change; Vint_z single pulse after the 500th ch_ref edge; vint=0 afterward; sat=0, erro=0.
- Full loop with maquina_de_estados + bcd_controlador_3digitos: inicio pulse, vm=250, vref=500 -> Vint_z pulse ends the conversion; displayed count 500 (±1 per documented FSM latency); second inicio reproduces the same value.
- Saturation: ACC_W=12, vm=1023, ch_vm 5 cycles -> vint=4095 and sat=1 from the 5th edge; ch_zr one cycle -> vint=0, sat=0.
- Re-arm rule: vint=300, vref=100, ch_ref held 10 cycles -> exactly one Vint_z pulse (3rd edge). HOLD 1 cycle then ch_ref 2 cycles -> one pulse on the first edge (vint==0).
- Illegal and zero-reference controls: ch_vm=ch_ref=1 -> erro=1, vint unchanged, no pulse. ch_ref with vref=0 and vint=700 -> erro=1, vint stays 700, no pulse.
- Reset mid-ramp: rst_s=1 during DESINTEGRA with vint=12345 -> next edge vint=0, Vint_z=0, armado=1; no pulse while rst_s high.
